// File: rtl/dec_counter.sv
// Loadable saturating down-counter with zero detect, used as a countdown/timeout element.
// A load takes priority over a decrement in the same cycle.
module dec_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             dec,
  output logic             zero,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_is_zero;

  assign cnt_is_zero = (cnt_q == '0);

  // Decrement saturates at zero instead of wrapping to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (latch) begin
      cnt_d = in;
    end else if (dec && !cnt_is_zero) begin
      cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = cnt_is_zero;

endmodule

// File: tb/tb_dec_counter.sv
// Directed vector bench for dec_counter: a table of single-edge vectors plus
// hand-written sequences for reset, long decrement runs and hold behaviour.
module tb_dec_counter;

  localparam int WIDTH = 32;
  localparam int NVEC  = 14;

  typedef struct {
    logic             latch;
    logic             dec;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_count;
    logic             exp_zero;
  } vec_t;

  logic             clock;
  logic             reset_n;
  logic [WIDTH-1:0] in;
  logic             latch;
  logic             dec;
  logic             zero;
  logic [WIDTH-1:0] count;

  int checks = 0;
  int errors = 0;

  vec_t vecs [NVEC];

  dec_counter #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .latch   (latch),
    .dec     (dec),
    .zero    (zero),
    .count   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [WIDTH-1:0] exp_count,
                       input logic exp_zero);
    checks++;
    if (count !== exp_count) begin
      errors++;
      $display("FAIL %s: count=%h expected %h", name, count, exp_count);
    end
    checks++;
    if (zero !== exp_zero) begin
      errors++;
      $display("FAIL %s: zero=%b expected %b", name, zero, exp_zero);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1ns later.
  task automatic step(input logic l, input logic d, input logic [WIDTH-1:0] v);
    latch = l;
    dec   = d;
    in    = v;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd3,          32'd3,          1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'd0,          32'd2,          1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd0,          32'd1,          1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'd0,          32'd0,          1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'd0,          32'd0,          1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'd10,         32'd10,         1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'd7,          32'd7,          1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'd0,          32'd6,          1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,          32'd0,          1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'd0,          32'hFFFF_FFFE,  1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0100,  32'h0000_0100,  1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'hDEAD_BEEF,  32'h0000_0100,  1'b0};

    // Reset held with a pending load: counter must stay cleared.
    reset_n = 1'b0;
    latch   = 1'b1;
    dec     = 1'b0;
    in      = 32'h5555_5555;
    repeat (3) @(posedge clock);
    #1;
    $display("txn reset_hold count=%h zero=%b", count, zero);
    check("reset_hold", 32'd0, 1'b1);
    @(negedge clock);
    latch   = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    $display("txn after_release count=%h zero=%b", count, zero);
    check("after_release", 32'd0, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].latch, vecs[i].dec, vecs[i].din);
      $display("txn vec%0d latch=%b dec=%b in=%h count=%h zero=%b",
               i, vecs[i].latch, vecs[i].dec, vecs[i].din, count, zero);
      check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_zero);
    end

    // Hold for 20 edges with in changing and latch low.
    begin
      int bad_hold;
      bad_hold = 0;
      for (int i = 0; i < 20; i++) begin
        step(1'b0, 1'b0, 32'h1234_0000 + i);
        if (count !== 32'h0000_0100 || zero !== 1'b0) bad_hold++;
      end
      checks++;
      if (bad_hold != 0) begin
        errors++;
        $display("FAIL hold20: %0d cycles deviated, count=%h expected 00000100",
                 bad_hold, count);
      end
      $display("txn hold20 count=%h zero=%b", count, zero);
    end

    // Load 0x5555_5555 then 100 decrements; zero must never assert.
    step(1'b1, 1'b0, 32'h5555_5555);
    check("load_5555", 32'h5555_5555, 1'b0);
    begin
      int zero_seen;
      zero_seen = 0;
      for (int i = 0; i < 100; i++) begin
        step(1'b0, 1'b1, 32'h0);
        if (zero !== 1'b0) zero_seen++;
      end
      checks++;
      if (zero_seen != 0) begin
        errors++;
        $display("FAIL dec100_zero: zero high on %0d cycles, required 0", zero_seen);
      end
    end
    $display("txn dec100 count=%h zero=%b", count, zero);
    check("dec100", 32'h5555_54F1, 1'b0);

    // Asynchronous reset mid-cycle must clear before the next edge.
    step(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("load_a5", 32'hA5A5_A5A5, 1'b0);
    latch = 1'b0;
    dec   = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    $display("txn async_reset count=%h zero=%b", count, zero);
    check("async_reset", 32'd0, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 32'h0);
    check("dec_after_reset", 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd1);
    check("load_one", 32'd1, 1'b0);
    step(1'b0, 1'b1, 32'd0);
    check("one_to_zero", 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
